// File: rtl/float_to_double_arbiter.sv
// float_to_double_arbiter: shares one float-to-double converter between two
// handshake channels, alternating grants when both request at once.
module float_to_double_arbiter #(
    parameter logic PRIORITY_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [63:0] output_a,
    output logic        output_a_stb,
    input  logic        output_a_ack,
    output logic [63:0] output_b,
    output logic        output_b_stb,
    input  logic        output_b_ack,
    output logic [31:0] conv_in,
    output logic        conv_in_stb,
    input  logic        conv_in_ack,
    input  logic [63:0] conv_out,
    input  logic        conv_out_stb,
    output logic        conv_out_ack,
    output logic        busy,
    output logic        grant
);
    typedef enum logic [2:0] {IDLE, GET, PUT_CONV, GET_CONV, PUT_OUT} state_t;
    state_t      state;
    logic        last;
    logic        pick;
    logic [31:0] operand;
    logic [63:0] result;
    assign pick     = (input_a_stb && input_b_stb) ? ~last : input_b_stb;
    assign busy     = state != IDLE;
    assign conv_in  = operand;
    assign output_a = result;
    assign output_b = result;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last         <= ~PRIORITY_FIRST;
            grant        <= PRIORITY_FIRST;
            operand      <= '0;
            result       <= '0;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            conv_in_stb  <= 1'b0;
            conv_out_ack <= 1'b0;
            output_a_stb <= 1'b0;
            output_b_stb <= 1'b0;
        end else begin
            case (state)
                IDLE: if (input_a_stb || input_b_stb) begin
                    grant       <= pick;
                    input_a_ack <= ~pick;
                    input_b_ack <= pick;
                    state       <= GET;
                end
                GET: if (grant ? input_b_stb : input_a_stb) begin
                    operand     <= grant ? input_b : input_a;
                    input_a_ack <= 1'b0;
                    input_b_ack <= 1'b0;
                    conv_in_stb <= 1'b1;
                    state       <= PUT_CONV;
                end
                PUT_CONV: if (conv_in_ack) begin
                    conv_in_stb  <= 1'b0;
                    conv_out_ack <= 1'b1;
                    state        <= GET_CONV;
                end
                GET_CONV: if (conv_out_stb) begin
                    result       <= conv_out;
                    conv_out_ack <= 1'b0;
                    output_a_stb <= ~grant;
                    output_b_stb <= grant;
                    state        <= PUT_OUT;
                end
                PUT_OUT: if (grant ? output_b_ack : output_a_ack) begin
                    output_a_stb <= 1'b0;
                    output_b_stb <= 1'b0;
                    last         <= grant;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_double_arbiter.sv
// tb_float_to_double_arbiter: directed vectors against the arbiter with a
// behavioural one-cycle float-to-double converter on the shared port.
module tb_float_to_double_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a, input_b, conv_in;
    logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
    logic [63:0] output_a, output_b, conv_out;
    logic        output_a_stb, output_a_ack, output_b_stb, output_b_ack;
    logic        conv_in_stb, conv_in_ack, conv_out_stb, conv_out_ack;
    logic        busy, grant;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          out_cyc = 0;
    int          b_stb_cnt = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int          qch[$];
    int          na0, nb0, nc0, start_cyc;

    always #5 clk = ~clk;

    float_to_double_arbiter #(.PRIORITY_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(output_a_ack),
        .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(output_b_ack),
        .conv_in(conv_in), .conv_in_stb(conv_in_stb), .conv_in_ack(conv_in_ack),
        .conv_out(conv_out), .conv_out_stb(conv_out_stb), .conv_out_ack(conv_out_ack),
        .busy(busy), .grant(grant)
    );

    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        e = (f[30:23] == 8'h00) ? 11'd0 :
            (f[30:23] == 8'hFF) ? 11'h7FF : {3'b000, f[30:23]} + 11'd896;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    // Converter model: accepts immediately, presents its result one cycle later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_out_stb <= 1'b0;
            conv_out     <= '0;
        end else if (conv_out_stb && conv_out_ack) begin
            conv_out_stb <= 1'b0;
        end else if (conv_in_stb && conv_in_ack && !conv_out_stb) begin
            conv_out     <= f2d(conv_in);
            conv_out_stb <= 1'b1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (output_a_stb && output_a_ack) begin
            qa.push_back(output_a);
            qch.push_back(0);
            out_cyc = cyc;
        end
        if (output_b_stb && output_b_ack) begin
            qb.push_back(output_b);
            qch.push_back(1);
            out_cyc = cyc;
        end
        if (output_b_stb) b_stb_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic mark();
        na0 = qa.size();
        nb0 = qb.size();
        nc0 = qch.size();
    endtask

    task automatic send(input logic ch, input logic [31:0] d, input logic keep);
        logic got;
        got = 1'b0;
        if (ch) begin input_b = d; input_b_stb = 1'b1; end
        else    begin input_a = d; input_a_stb = 1'b1; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = ch ? input_b_ack : input_a_ack;
        end
        check(ch ? "send_b_ack" : "send_a_ack", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        if (!keep) begin
            if (ch) input_b_stb = 1'b0;
            else    input_a_stb = 1'b0;
        end
    endtask

    task automatic wait_results(input int n);
        int have;
        have = 0;
        for (int i = 0; i < 400 && have < n; i++) begin
            @(negedge clk);
            have = qch.size() - nc0;
        end
        check("result_count", 64'(have), 64'(n));
    endtask

    logic [31:0] sa[4] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h41200000};
    logic [63:0] ea[4] = '{64'h3FF0000000000000, 64'h4000000000000000,
                           64'h3FE0000000000000, 64'h4024000000000000};
    logic [31:0] sb[4] = '{32'hC0000000, 32'h40490FDB, 32'hBF800000, 32'h3E800000};
    logic [63:0] eb[4] = '{64'hC000000000000000, 64'h400921FB60000000,
                           64'hBFF0000000000000, 64'h3FD0000000000000};

    initial begin
        input_a = '0; input_b = '0;
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        output_a_ack = 1'b1; output_b_ack = 1'b1;
        conv_in_ack = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset_hs", 64'({input_a_ack, input_b_ack, output_a_stb, output_b_stb,
                               conv_in_stb, conv_out_ack, busy}), 64'(0));
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_data", {output_a[31:0], conv_in}, 64'(0));
        do_reset();

        // Single a, with latency from request to output handshake
        mark();
        start_cyc = cyc;
        send(1'b0, 32'h3F800000, 1'b0);
        wait_results(1);
        check("single_a", qa[na0], 64'h3FF0000000000000);
        check("single_a_no_b_stb", 64'(b_stb_cnt), 64'(0));
        check("latency", 64'(out_cyc - start_cyc), 64'(4));
        @(posedge clk);
        #1 check("idle_after_a", 64'(busy), 64'(0));

        // Single b
        mark();
        send(1'b1, 32'hC0000000, 1'b0);
        check("single_b_grant", 64'(grant), 64'(1));
        check("single_b_busy", 64'(busy), 64'(1));
        wait_results(1);
        check("single_b", qb[nb0], 64'hC000000000000000);

        // Simultaneous after reset: a first
        do_reset();
        mark();
        fork
            send(1'b0, 32'h3F800000, 1'b0);
            send(1'b1, 32'h40490FDB, 1'b0);
        join
        wait_results(2);
        check("simul_first", 64'(qch[nc0]), 64'(0));
        check("simul_second", 64'(qch[nc0 + 1]), 64'(1));
        check("simul_a", qa[na0], 64'h3FF0000000000000);
        check("simul_b", qb[nb0], 64'h400921FB60000000);

        // Both streaming 4 words
        do_reset();
        mark();
        fork
            for (int i = 0; i < 4; i++) send(1'b0, sa[i], i < 3);
            for (int i = 0; i < 4; i++) send(1'b1, sb[i], i < 3);
        join
        wait_results(8);
        for (int i = 0; i < 8; i++) check("stream_order", 64'(qch[nc0 + i]), 64'(i % 2));
        for (int i = 0; i < 4; i++) begin
            check("stream_a", qa[na0 + i], ea[i]);
            check("stream_b", qb[nb0 + i], eb[i]);
        end

        // Output stall on b with a waiting
        mark();
        output_b_ack = 1'b0;
        send(1'b1, 32'h40490FDB, 1'b0);
        for (int i = 0; i < 50 && !output_b_stb; i++) @(negedge clk);
        check("stall_b_stb", 64'(output_b_stb), 64'(1));
        input_a = 32'h3F800000;
        input_a_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_a_ack", 64'(input_a_ack), 64'(0));
            check("stall_conv_stb", 64'(conv_in_stb), 64'(0));
            check("stall_out_b", output_b, 64'h400921FB60000000);
        end
        @(posedge clk);
        #1 output_b_ack = 1'b1;
        send(1'b0, 32'h3F800000, 1'b0);
        wait_results(2);
        check("stall_b", qb[nb0], 64'h400921FB60000000);
        check("stall_a", qa[na0], 64'h3FF0000000000000);
        check("stall_order", 64'(qch[nc0]), 64'(1));

        // Reset during GET_CONV
        mark();
        send(1'b0, 32'h40000000, 1'b0);
        for (int i = 0; i < 50 && !conv_out_ack; i++) @(negedge clk);
        check("in_get_conv", 64'(conv_out_ack), 64'(1));
        #1 rst = 1'b0;
        #1;
        check("rst_hs", 64'({input_a_ack, input_b_ack, output_a_stb, output_b_stb,
                             conv_in_stb, conv_out_ack, conv_out_stb, busy}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_result", 64'(qch.size() - nc0), 64'(0));
        send(1'b1, 32'hBF800000, 1'b0);
        wait_results(1);
        check("rst_next_b", qb[nb0], 64'hBFF0000000000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
